// File: rtl/multiply_divide_unit_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states and
// small opcode classification helpers.
package multiply_divide_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_operation_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  function automatic logic is_signed_op(input md_operation_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_operation_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_op(input md_operation_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/multiply_divide_unit.sv
// Iterative radix-2 multiply/divide engine that owns HI/LO. Operates on
// magnitudes and applies the result signs in a final FIX cycle.
module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  md_operation_t         opCode,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int COUNT_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DATA_WIDTH - 1);

  md_state_t               state_q, state_d;
  md_operation_t           op_q, op_d;
  logic [COUNT_WIDTH-1:0]  counter_q, counter_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   quot_q, quot_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic [DATA_WIDTH-1:0]   dividend_q, dividend_d;
  logic                    res_neg_q, res_neg_d;
  logic                    rem_neg_q, rem_neg_d;
  logic                    div_zero_q, div_zero_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;

  logic                    a_neg_s, b_neg_s;
  logic [DATA_WIDTH-1:0]   a_abs_s, b_abs_s;
  logic [DATA_WIDTH:0]     mul_sum_s;
  logic [DATA_WIDTH:0]     div_shift_s;
  logic [DATA_WIDTH-1:0]   div_diff_s;
  logic                    div_ok_s;
  logic [2*DATA_WIDTH-1:0] prod_fix_s;
  logic [DATA_WIDTH-1:0]   quot_fix_s, rem_fix_s;

  assign a_neg_s = is_signed_op(opCode) & operand1[DATA_WIDTH-1];
  assign b_neg_s = is_signed_op(opCode) & operand2[DATA_WIDTH-1];
  assign a_abs_s = a_neg_s ? -operand1 : operand1;
  assign b_abs_s = b_neg_s ? -operand2 : operand2;

  // Multiply: prod_q = {partial sum, remaining multiplier bits}, shifted right each step.
  assign mul_sum_s = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + {1'b0, (prod_q[0] ? opb_q : {DATA_WIDTH{1'b0}})};

  // Divide: quot_q starts as the dividend and its MSB feeds the remainder each step.
  assign div_shift_s = {rem_q, quot_q[DATA_WIDTH-1]};
  assign div_ok_s    = (div_shift_s >= {1'b0, opb_q});
  assign div_diff_s  = div_shift_s[DATA_WIDTH-1:0] - opb_q;

  assign prod_fix_s = res_neg_q ? -prod_q : prod_q;
  assign quot_fix_s = res_neg_q ? -quot_q : quot_q;
  assign rem_fix_s  = rem_neg_q ? -rem_q : rem_q;

  // Next-state and datapath update for the IDLE/RUN/FIX sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    counter_d  = counter_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    opb_d      = opb_q;
    dividend_d = dividend_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      MD_IDLE: begin
        if (start && is_md_op(opCode)) begin
          state_d    = MD_RUN;
          busy_d     = 1'b1;
          op_d       = opCode;
          counter_d  = {COUNT_WIDTH{1'b0}};
          prod_d     = {{DATA_WIDTH{1'b0}}, b_abs_s};
          rem_d      = {DATA_WIDTH{1'b0}};
          quot_d     = a_abs_s;
          opb_d      = is_div_op(opCode) ? b_abs_s : a_abs_s;
          dividend_d = operand1;
          res_neg_d  = a_neg_s ^ b_neg_s;
          rem_neg_d  = a_neg_s;
          div_zero_d = (operand2 == {DATA_WIDTH{1'b0}});
        end else if (start && (opCode == MD_MTHI)) begin
          hi_d = operand1;
        end else if (start && (opCode == MD_MTLO)) begin
          lo_d = operand1;
        end else begin
          busy_d = 1'b0;
        end
      end
      MD_RUN: begin
        if (is_div_op(op_q)) begin
          if (div_ok_s) begin
            rem_d  = div_diff_s;
            quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = div_shift_s[DATA_WIDTH-1:0];
            quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          prod_d = {mul_sum_s, prod_q[DATA_WIDTH-1:1]};
        end
        counter_d = counter_q + COUNT_WIDTH'(1);
        if (counter_q == LAST_COUNT) begin
          state_d = MD_FIX;
        end else begin
          state_d = MD_RUN;
        end
      end
      MD_FIX: begin
        if (is_div_op(op_q) && div_zero_q) begin
          hi_d = dividend_q;
          lo_d = {DATA_WIDTH{1'b1}};
        end else if (is_div_op(op_q)) begin
          hi_d = rem_fix_s;
          lo_d = quot_fix_s;
        end else begin
          hi_d = prod_fix_s[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_d = prod_fix_s[DATA_WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A squash overrides everything, including an MTHI/MTLO or a FIX write.
    if (flush) begin
      state_d = MD_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end else begin
      done_d = done_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_MULT;
      counter_q  <= {COUNT_WIDTH{1'b0}};
      prod_q     <= {(2*DATA_WIDTH){1'b0}};
      rem_q      <= {DATA_WIDTH{1'b0}};
      quot_q     <= {DATA_WIDTH{1'b0}};
      opb_q      <= {DATA_WIDTH{1'b0}};
      dividend_q <= {DATA_WIDTH{1'b0}};
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= {DATA_WIDTH{1'b0}};
      lo_q       <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      counter_q  <= counter_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      opb_q      <= opb_d;
      dividend_q <= dividend_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Self-checking bench for multiply_divide_unit: directed vector table, corner
// sequences (flush, reset, ignored start) and randomized ops vs. an arithmetic model.
module tb_multiply_divide_unit;
  import multiply_divide_unit_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  md_operation_t op_s = MD_MULT;
  logic [31:0]   operand1 = 32'h0;
  logic [31:0]   operand2 = 32'h0;
  logic          flush = 1'b0;
  logic          busy, done;
  logic [31:0]   hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    md_operation_t op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   exp_hi;
    logic [31:0]   exp_lo;
  } vec_t;
  vec_t vecs[9];

  multiply_divide_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .opCode(op_s),
    .operand1(operand1), .operand2(operand2), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model_op(input md_operation_t op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] ch,
                                           input logic [31:0] cl);
    longint q, r;
    logic [63:0] pu;
    case (op)
      MD_MULT:  begin q = longint'($signed(a)) * longint'($signed(b)); return q; end
      MD_MULTU: begin pu = {32'h0, a} * {32'h0, b}; return pu; end
      MD_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      MD_MTHI: return {a, cl};
      MD_MTLO: return {ch, a};
      default: return {ch, cl};
    endcase
  endfunction

  task automatic issue(input md_operation_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    @(negedge clk);
    start = 1'b1; op_s = op; operand1 = a; operand2 = b; flush = fl;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
  endtask

  // Counts edges until done; busy must stay high until the done sample.
  task automatic wait_done(output int lat, output int busy_bad);
    bit seen = 1'b0;
    lat = 0; busy_bad = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1; lat = k;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  task automatic run_md(input string name, input md_operation_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat, bad;
    issue(op, a, b, 1'b0);
    check({name, "_busy_e0"}, {31'h0, busy}, 32'h1);
    wait_done(lat, bad);
    check({name, "_latency"}, lat, 32'd33);
    check({name, "_busy_hold"}, bad, 32'd0);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    m_hi = eh; m_lo = el;
  endtask

  task automatic run_mt(input string name, input md_operation_t op, input logic [31:0] a);
    logic [63:0] e;
    e = model_op(op, a, 32'h0, m_hi, m_lo);
    issue(op, a, 32'h0, 1'b0);
    check({name, "_hi"}, hi, e[63:32]);
    check({name, "_lo"}, lo, e[31:0]);
    check({name, "_nodone"}, {31'h0, done | busy}, 32'h0);
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  initial begin
    int lat, bad, n;
    logic [63:0] e;
    md_operation_t rop;
    logic [31:0] ra, rb;

    vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[7] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;

    for (int i = 0; i < 9; i++)
      run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    run_mt("mthi", MD_MTHI, 32'hA5A5A5A5);
    run_mt("mtlo", MD_MTLO, 32'h5A5A0001);

    // Second start while busy must be ignored.
    issue(MD_MULTU, 32'd6, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    issue(MD_DIVU, 32'd100, 32'd3, 1'b0);
    wait_done(lat, bad);
    check("ign_latency", lat, 32'd28);
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'd42);
    count_done(40, n);
    check("ign_no_second_done", n, 32'd0);
    m_hi = 32'h0; m_lo = 32'd42;

    // Flush at cycle 10 of a MULT.
    issue(MD_MULT, 32'h00001111, 32'h00002222, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {31'h0, busy}, 32'h0);
    count_done(40, n);
    check("flush_no_done", n, 32'd0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);

    // Flush in the FIX cycle suppresses write and done.
    issue(MD_MULTU, 32'd9, 32'd9, 1'b0);
    repeat (32) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("fixflush_done", {31'h0, done | busy}, 32'h0);
    count_done(5, n);
    check("fixflush_no_done", n, 32'd0);
    check("fixflush_hi", hi, m_hi);
    check("fixflush_lo", lo, m_lo);

    // Flush together with MTHI in IDLE: no write.
    issue(MD_MTHI, 32'h12345678, 32'h0, 1'b1);
    check("flush_mthi_hi", hi, m_hi);
    check("flush_mthi_lo", lo, m_lo);

    // Reset in the middle of a DIV.
    issue(MD_DIV, 32'h00ABCDEF, 32'h00000013, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    @(negedge clk); reset = 1'b0;
    run_md("post_rst_multu", MD_MULTU, 32'd2, 32'd3, 32'h0, 32'd6);

    for (int i = 0; i < 24; i++) begin
      rop = md_operation_t'($urandom_range(5, 0));
      ra  = $urandom;
      rb  = ($urandom_range(7, 0) == 0) ? 32'h0 :
            ($urandom_range(1, 0) == 0) ? $urandom : 32'($urandom_range(300, 1));
      if (is_md_op(rop)) begin
        e = model_op(rop, ra, rb, m_hi, m_lo);
        run_md($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, e[63:32], e[31:0]);
      end else begin
        run_mt($sformatf("rnd%0d_op%0d", i, rop), rop, ra);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
